// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory-port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEFAULT  = 6;
  localparam int BLOCK_W_DEFAULT = 128;

  localparam logic REGION_I = 1'b0;
  localparam logic REGION_D = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RESP_I,
    RESP_D
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one block-wide memory port between the instruction and data caches,
// alternating grants on contention and presenting one access at a time.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no access in flight; pick a requester and latch its request
// SERVE_I | instruction read on the memory port, waiting for busywait low
// SERVE_D | data read or write-back on the memory port
// RESP_I  | instruction block ready; icache busywait low for this cycle
// RESP_D  | data access done; dcache busywait low for this cycle
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int BLOCK_W = BLOCK_W_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ic_read,
  input  logic [ADDR_W-1:0]  ic_address,
  output logic [BLOCK_W-1:0] ic_readdata,
  output logic               ic_busywait,
  input  logic               dc_read,
  input  logic               dc_write,
  input  logic [ADDR_W-1:0]  dc_address,
  input  logic [BLOCK_W-1:0] dc_writedata,
  output logic [BLOCK_W-1:0] dc_readdata,
  output logic               dc_busywait,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W:0]    mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait
);

  arb_state_t         state;
  arb_state_t         state_next;
  port_t              last_grant;
  logic [ADDR_W-1:0]  lat_address;
  logic               lat_write;
  logic [BLOCK_W-1:0] lat_writedata;
  logic [BLOCK_W-1:0] ic_rdata_q;
  logic [BLOCK_W-1:0] dc_rdata_q;
  logic               ic_req;
  logic               dc_req;
  logic               pick_d;

  // On a tie the port that was not served last wins.
  always_comb begin
    ic_req = ic_read;
    dc_req = dc_read | dc_write;
    if (ic_req && dc_req) begin
      pick_d = (last_grant == PORT_I);
    end else begin
      pick_d = dc_req;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      last_grant    <= PORT_I;
      lat_address   <= '0;
      lat_write     <= 1'b0;
      lat_writedata <= '0;
      ic_rdata_q    <= '0;
      dc_rdata_q    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (ic_req || dc_req) begin
            if (pick_d) begin
              lat_address   <= dc_address;
              lat_write     <= dc_write;
              lat_writedata <= dc_write ? dc_writedata : '0;
            end else begin
              lat_address   <= ic_address;
              lat_write     <= 1'b0;
              lat_writedata <= '0;
            end
          end
        end
        SERVE_I: begin
          if (!mem_busywait) begin
            ic_rdata_q <= mem_readdata;
            last_grant <= PORT_I;
          end
        end
        SERVE_D: begin
          if (!mem_busywait) begin
            if (!lat_write) begin
              dc_rdata_q <= mem_readdata;
            end
            last_grant <= PORT_D;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (ic_req || dc_req) begin
          state_next = pick_d ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I: if (!mem_busywait) state_next = RESP_I;
      SERVE_D: if (!mem_busywait) state_next = RESP_D;
      RESP_I:  state_next = IDLE;
      RESP_D:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory side is driven only from latched copies, so it stays stable during SERVE.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state)
      SERVE_I: begin
        mem_read    = 1'b1;
        mem_address = {REGION_I, lat_address};
      end
      SERVE_D: begin
        mem_read      = !lat_write;
        mem_write     = lat_write;
        mem_address   = {REGION_D, lat_address};
        mem_writedata = lat_write ? lat_writedata : '0;
      end
      default: ;
    endcase
  end

  assign ic_busywait = ic_req & (state != RESP_I);
  assign dc_busywait = dc_req & (state != RESP_D);
  assign ic_readdata = ic_rdata_q;
  assign dc_readdata = dc_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: cache agents queue expected memory
// accesses and returned blocks; monitors on both sides pop and compare.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic         w;
    logic [6:0]   a;
    logic [127:0] d;
  } mexp_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         ic_read;
  logic [5:0]   ic_address;
  logic [127:0] ic_readdata;
  logic         ic_busywait;
  logic         dc_read;
  logic         dc_write;
  logic [5:0]   dc_address;
  logic [127:0] dc_writedata;
  logic [127:0] dc_readdata;
  logic         dc_busywait;
  logic         mem_read;
  logic         mem_write;
  logic [6:0]   mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int total = 0;
  int bad   = 0;

  mexp_t        q_mi[$];
  mexp_t        q_md[$];
  logic [127:0] q_ri[$];
  logic [127:0] q_rd[$];
  logic [127:0] ref_mem [128];
  logic [127:0] last_dc_rd;

  logic [127:0] mem_arr [128];
  bit           mem_init = 1'b0;
  int           cnt      = 0;
  int           cur_lat  = 4;
  int           fix_lat  = 4;
  bit           rand_lat = 1'b0;

  mem_port_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .ic_read      (ic_read),
    .ic_address   (ic_address),
    .ic_readdata  (ic_readdata),
    .ic_busywait  (ic_busywait),
    .dc_read      (dc_read),
    .dc_write     (dc_write),
    .dc_address   (dc_address),
    .dc_writedata (dc_writedata),
    .dc_readdata  (dc_readdata),
    .dc_busywait  (dc_busywait),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  always #5 clock = ~clock;

  function automatic logic [127:0] pat(input int i);
    logic [127:0] v;
    v = {16{8'hA5}};
    v[7:0] = v[7:0] ^ 8'(i);
    v[127:120] = v[127:120] ^ 8'(i * 3);
    return v;
  endfunction

  function automatic mexp_t mk(input logic w, input logic [6:0] a, input logic [127:0] d);
    mexp_t e;
    e.w = w;
    e.a = a;
    e.d = d;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory: busy for cur_lat edges after the strobe appears, then completes.
  assign mem_busywait = (mem_read | mem_write) && (cnt < cur_lat);
  assign mem_readdata = mem_arr[mem_address];

  always @(posedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 128; i++) mem_arr[i] <= pat(i);
      mem_init <= 1'b1;
    end
    if (mem_read | mem_write) begin
      if (cnt < cur_lat) begin
        cnt <= cnt + 1;
      end else begin
        if (mem_write) mem_arr[mem_address] <= mem_writedata;
        cnt <= 0;
      end
    end else begin
      cnt     <= 0;
      cur_lat <= rand_lat ? int'($urandom_range(0, 5)) : fix_lat;
    end
  end

  // Memory-side monitor: arbitration order, access contents, stability.
  bit           last_srv = 1'b0;
  bit           in_acc   = 1'b0;
  logic [6:0]   acc_a;
  logic [127:0] acc_d;
  logic         acc_w;

  always @(negedge clock) begin
    mexp_t e;
    logic  win;
    logic  exp_win;
    if (!reset) begin
      last_srv = 1'b0;
      in_acc   = 1'b0;
    end else if (mem_read | mem_write) begin
      chk("one_strobe", 128'(mem_read & mem_write), 128'(0));
      if (!in_acc) begin
        win = mem_address[6];
        if (ic_read && (dc_read || dc_write)) exp_win = ~last_srv;
        else exp_win = ic_read ? 1'b0 : 1'b1;
        chk("rr_winner", 128'(win), 128'(exp_win));
        e = mk(1'b0, 7'h00, '0);
        if (win == 1'b0) begin
          if (q_mi.size() == 0) chk("unexpected_i_access", 128'(1), 128'(0));
          else e = q_mi.pop_front();
        end else begin
          if (q_md.size() == 0) chk("unexpected_d_access", 128'(1), 128'(0));
          else e = q_md.pop_front();
        end
        chk("mem_op", {mem_read, mem_write, mem_address}, {~e.w, e.w, e.a});
        chk("mem_wdata", mem_writedata, e.d);
        acc_a    = mem_address;
        acc_d    = mem_writedata;
        acc_w    = mem_write;
        in_acc   = 1'b1;
        last_srv = win;
      end else begin
        chk("mem_stable", {mem_write, mem_read, mem_address}, {acc_w, ~acc_w, acc_a});
        chk("wdata_stable", mem_writedata, acc_d);
      end
    end else begin
      in_acc = 1'b0;
    end
  end

  // Cache-side monitor: returned block on the response cycle.
  always @(negedge clock) begin
    if (reset) begin
      if (ic_read && !ic_busywait) begin
        if (q_ri.size() == 0) chk("unexpected_ic_resp", 128'(1), 128'(0));
        else chk("ic_readdata", ic_readdata, q_ri.pop_front());
      end
      if ((dc_read || dc_write) && !dc_busywait) begin
        if (q_rd.size() == 0) chk("unexpected_dc_resp", 128'(1), 128'(0));
        else chk("dc_readdata", dc_readdata, q_rd.pop_front());
      end
    end
  end

  task automatic do_ic(input logic [5:0] a, input bit align, input bit hold, output int stall);
    int n;
    if (align) begin
      @(negedge clock);
      #1;
    end
    q_mi.push_back(mk(1'b0, {1'b0, a}, '0));
    q_ri.push_back(ref_mem[{1'b0, a}]);
    ic_address = a;
    ic_read    = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      #1;
      n++;
    end while (ic_busywait && n < 300);
    if (ic_busywait) chk("ic_timeout", 128'(1), 128'(0));
    stall = n;
    if (hold) begin
      @(negedge clock);
      #1;
      chk("ic_bw_one_cycle", 128'(ic_busywait), 128'(1));
    end
    ic_read = 1'b0;
  endtask

  task automatic do_dc(input logic w, input logic [5:0] a, input logic [127:0] d,
                       input bit align, output int stall);
    int n;
    if (align) begin
      @(negedge clock);
      #1;
    end
    q_md.push_back(mk(w, {1'b1, a}, w ? d : '0));
    if (w) begin
      ref_mem[{1'b1, a}] = d;
      q_rd.push_back(last_dc_rd);
    end else begin
      last_dc_rd = ref_mem[{1'b1, a}];
      q_rd.push_back(last_dc_rd);
    end
    dc_address   = a;
    dc_writedata = d;
    dc_write     = w;
    dc_read      = !w;
    n = 0;
    do begin
      @(negedge clock);
      #1;
      n++;
    end while (dc_busywait && n < 300);
    if (dc_busywait) chk("dc_timeout", 128'(1), 128'(0));
    stall    = n;
    dc_read  = 1'b0;
    dc_write = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_i, s_d;
    int k;
    reset = 1'b0;
    ic_read = 1'b0; ic_address = '0;
    dc_read = 1'b0; dc_write = 1'b0; dc_address = '0; dc_writedata = '0;
    last_dc_rd = '0;
    for (int i = 0; i < 128; i++) ref_mem[i] = pat(i);

    repeat (3) @(negedge clock);
    chk("rst_mem_read", 128'(mem_read), 128'(0));
    chk("rst_mem_write", 128'(mem_write), 128'(0));
    chk("rst_mem_address", 128'(mem_address), 128'(0));
    chk("rst_mem_wdata", mem_writedata, 128'(0));
    chk("rst_ic_readdata", ic_readdata, 128'(0));
    chk("rst_dc_readdata", dc_readdata, 128'(0));
    chk("rst_busywaits", 128'({ic_busywait, dc_busywait}), 128'(0));
    #1 ic_read = 1'b1;
    #1 chk("rst_ic_bw_follows", 128'(ic_busywait), 128'(1));
    ic_read = 1'b0; dc_write = 1'b1;
    #1 chk("rst_dc_bw_follows", 128'(dc_busywait), 128'(1));
    dc_write = 1'b0;
    @(negedge clock);
    #1 reset = 1'b1;

    // single icache read, latency 4, request held one cycle past the response
    do_ic(6'h05, 1'b1, 1'b1, s_i);
    chk("ic_stall_n4", 128'(s_i), 128'(6));

    // write-back then read-back of the same data block
    do_dc(1'b1, 6'h3F, 128'h1234, 1'b1, s_d);
    chk("dc_wr_stall_n4", 128'(s_d), 128'(6));
    do_dc(1'b0, 6'h3F, '0, 1'b1, s_d);

    // simultaneous requests after reset: D first, then I, twice
    @(negedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    #1 reset = 1'b1;
    last_dc_rd = '0;
    for (int r = 0; r < 2; r++) begin
      fork
        do_ic(6'(8'h10 + r), 1'b1, 1'b0, s_i);
        do_dc(1'b0, 6'(8'h20 + r), '0, 1'b1, s_d);
      join
      chk("tie_winner_stall", 128'(s_d), 128'(6));
      chk("tie_loser_stall", 128'(s_i), 128'(13));
    end

    // reset in the middle of a data read
    do_dc(1'b0, 6'h22, '0, 1'b1, s_d);
    fix_lat = 20;
    @(negedge clock);
    #1;
    q_md.push_back(mk(1'b0, 7'h45, '0));
    dc_address = 6'h05;
    dc_read    = 1'b1;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!mem_read && k < 10);
    chk("abort_started", 128'(mem_read), 128'(1));
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("abort_strobes", 128'({mem_read, mem_write}), 128'(0));
    chk("abort_address", 128'(mem_address), 128'(0));
    chk("abort_dc_readdata", dc_readdata, 128'(0));
    chk("abort_dc_bw", 128'(dc_busywait), 128'(1));
    #1 dc_read = 1'b0;
    reset = 1'b1;
    last_dc_rd = '0;
    fix_lat = 4;

    // back-to-back instruction misses
    do_ic(6'h00, 1'b1, 1'b0, s_i);
    chk("ic_b2b_stall0", 128'(s_i), 128'(6));
    do_ic(6'h08, 1'b1, 1'b0, s_i);
    chk("ic_b2b_stall1", 128'(s_i), 128'(6));

    // dcache request arrives in the cycle the icache access completes
    fix_lat = 3;
    @(negedge clock);
    #1;
    fork
      do_ic(6'h2A, 1'b0, 1'b0, s_i);
      begin
        int m;
        m = 0;
        do begin
          @(negedge clock);
          m++;
        end while (!(mem_read && !mem_address[6] && !mem_busywait) && m < 50);
        #1;
        do_dc(1'b0, 6'h15, '0, 1'b0, s_d);
      end
    join
    chk("late_ic_stall", 128'(s_i), 128'(5));
    chk("late_dc_stall", 128'(s_d), 128'(7));

    // randomized traffic with random memory latency
    rand_lat = 1'b1;
    fork
      begin
        int st;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clock);
          do_ic(6'($urandom_range(0, 63)), 1'b1, 1'b0, st);
        end
      end
      begin
        int st;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clock);
          do_dc(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                {$urandom, $urandom, $urandom, $urandom}, 1'b1, st);
        end
      end
    join

    repeat (5) @(negedge clock);
    chk("drained_mem_i", 128'(q_mi.size()), 128'(0));
    chk("drained_mem_d", 128'(q_md.size()), 128'(0));
    chk("drained_resp", 128'(q_ri.size() + q_rd.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
